// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage and the core.
//
// Contents:
//   ADDR_W_DEF / INST_W_DEF  default PC and instruction widths
//   NOP_INST                 all-zero instruction, also the fetch output reset value
//   opcode_e                 4-bit opcode encoding shared with the core
//   opcode_of()              extracts the opcode field from an instruction
package cpu_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned INST_W_DEF = 16;

  localparam logic [INST_W_DEF-1:0] NOP_INST = '0;

  typedef enum logic [3:0] {
    OpNop   = 4'd0,
    OpLoad  = 4'd1,
    OpStore = 4'd2,
    OpSet   = 4'd3,
    OpLt    = 4'd4,
    OpEq    = 4'd5,
    OpBeq   = 4'd6,
    OpBneq  = 4'd7,
    OpAdd   = 4'd8,
    OpSub   = 4'd9,
    OpShl   = 4'd10,
    OpShr   = 4'd11,
    OpAnd   = 4'd12,
    OpOr    = 4'd13,
    OpInv   = 4'd14,
    OpXor   = 4'd15
  } opcode_e;

  // Opcode lives in the top four bits of the instruction word.
  function automatic opcode_e opcode_of(input logic [INST_W_DEF-1:0] word);
    return opcode_e'(word[INST_W_DEF-1 -: 4]);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO for the fetch stage.
//
// Synchronous FIFO of DEPTH entries (any DEPTH >= 2, not only powers of two).
// Entries are {instruction, pc}. A flush empties the FIFO in one edge and
// overrides any push or pop in the same cycle.
//
// Ports:
//   clk    in   clock, all state updates on the rising edge
//   rst    in   synchronous active-high reset
//   flush  in   discard all entries (and any push/pop this cycle)
//   push   in   write wdata at the tail
//   wdata  in   entry to write
//   pop    in   remove the head entry (ignored when empty)
//   rdata  out  head entry; holds the last shown value while empty
//   empty  out  no entries stored
//   count  out  number of entries stored
module fetch_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q;
  logic [PtrW-1:0]  rptr_q;
  logic [CntW-1:0]  count_q;
  logic [WIDTH-1:0] last_q;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(DEPTH - 1)) begin
      return '0;
    end
    return p + PtrW'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign do_push = push & ~flush;
  assign do_pop  = pop & ~flush & ~empty;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= ptr_inc(wptr_q);
      end
      if (do_pop) begin
        rptr_q <= ptr_inc(rptr_q);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CntW'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  // Remembers the head currently on rdata so the output holds while empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= '0;
    end else if (!empty) begin
      last_q <= mem_q[rptr_q];
    end
  end

  assign rdata = empty ? last_q : mem_q[rptr_q];
  assign count = count_q;

  // The upstream credit check must never let a push land on a full FIFO.
  always_ff @(posedge clk) begin
    if (!rst && do_push && !do_pop) begin
      assert (count_q != CntW'(DEPTH))
        else $error("fetch_fifo overflow");
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage.
//
// Owns the fetch PC (fpc), drives the synchronous instruction ROM (one-cycle
// read latency), buffers returned words with their PC in a prefetch FIFO and
// hands them to the core over a valid/ready handshake. A redirect from the
// core flushes the FIFO, drops the in-flight ROM read and restarts fetch.
//
// Ports:
//   clk             in   clock
//   rst             in   synchronous active-high reset
//   rom_addr        out  ROM read address (the fetch PC register)
//   rom_inst        in   ROM data, valid one cycle after rom_addr
//   inst_valid      out  FIFO head holds a valid instruction
//   inst_ready      in   core accepts the head this cycle
//   inst            out  instruction at the FIFO head
//   inst_pc         out  PC of the head instruction
//   redirect_valid  in   restart fetch at redirect_pc
//   redirect_pc     in   restart target
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned INST_W = INST_W_DEF,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_inst,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int unsigned EntW = INST_W + ADDR_W;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] fpc_q, fpc_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;   // PC of the word currently in the ROM
  logic              pend_q, pend_d; // ROM output this cycle must be captured
  logic              issue;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic [CntW-1:0]   fifo_count;
  logic [EntW-1:0]   fifo_head;
  logic [31:0]       need;
  logic [31:0]       room;

  // Redirect masks the head so no transfer can happen in a redirect cycle.
  assign inst_valid = ~fifo_empty & ~redirect_valid;
  assign pop        = inst_valid & inst_ready;
  // The in-flight word is wrong-path when a redirect arrives: drop it.
  assign push       = pend_q & ~redirect_valid;

  // Credit check: issue only if the slot for this address is guaranteed
  // after counting what leaves now and what is already in flight.
  // Written as count + pend + 1 <= DEPTH + pop to stay unsigned.
  always_comb begin
    need  = 32'(fifo_count) + 32'(pend_q) + 32'd1;
    room  = DEPTH + 32'(pop);
    issue = ~redirect_valid & (need <= room);

    fpc_d  = fpc_q;
    ipc_d  = ipc_q;
    pend_d = issue;

    if (redirect_valid) begin
      fpc_d = redirect_pc;
    end else if (issue) begin
      fpc_d = fpc_q + ADDR_W'(1);
      ipc_d = fpc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc_q  <= '0;
      ipc_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      fpc_q  <= fpc_d;
      ipc_q  <= ipc_d;
      pend_q <= pend_d;
    end
  end

  fetch_fifo #(
    .WIDTH(EntW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .flush(redirect_valid),
    .push (push),
    .wdata({rom_inst, ipc_q}),
    .pop  (pop),
    .rdata(fifo_head),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  assign rom_addr = fpc_q;
  assign inst     = fifo_head[EntW-1 -: INST_W];
  assign inst_pc  = fifo_head[ADDR_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int unsigned AW = 8;
  localparam int unsigned IW = 16;
  localparam int unsigned D  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] rom_addr;
  logic [IW-1:0] rom_inst = '0;
  logic          inst_valid;
  logic          inst_ready = 1'b0;
  logic [IW-1:0] inst;
  logic [AW-1:0] inst_pc;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;

  logic [IW-1:0] rom [256];

  int n_tests = 0;
  int n_fail  = 0;

  fetch_unit #(
    .ADDR_W(AW),
    .INST_W(IW),
    .DEPTH (D)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rom_addr      (rom_addr),
    .rom_inst      (rom_inst),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  always #5 clk = ~clk;

  // Synchronous ROM, one-cycle read latency.
  always @(posedge clk) rom_inst <= rom[rom_addr];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Leaves the caller at the negedge of cycle R (first cycle with rst=0).
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    redirect_valid = 1'b0;
    inst_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    redirect_valid = 1'b0;
    inst_ready = 1'b1;
    @(negedge clk);
    #1;
    n_tests++;
    if ({inst_valid, inst, inst_pc, rom_addr} !== {1'b0, 16'h0000, 8'h00, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b inst=%h pc=%h addr=%h want 0/0000/00/00",
               inst_valid, inst, inst_pc, rom_addr);
    end
    rst = 1'b0;  // this cycle is R
    #1;
    n_tests++;
    if ({inst_valid, rom_addr} !== {1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_r: got v=%b addr=%h want 0/00", inst_valid, rom_addr);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if ({inst_valid, rom_addr} !== {1'b0, 8'h01}) begin
      n_fail++;
      $display("FAIL reset_r1: got v=%b addr=%h want 0/01", inst_valid, rom_addr);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, 8'h00, rom[0]}) begin
      n_fail++;
      $display("FAIL reset_r2: got v=%b pc=%h inst=%h want 1/00/%h",
               inst_valid, inst_pc, inst, rom[0]);
    end
  endtask

  task automatic test_streaming();
    logic [AW-1:0] exp;
    do_reset();
    inst_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);  // R+2
    exp = '0;
    for (int k = 0; k < 24; k++) begin
      #1;
      n_tests++;
      if ({inst_valid, inst_pc, inst} !== {1'b1, exp, rom[exp]}) begin
        n_fail++;
        $display("FAIL stream[%0d]: got v=%b pc=%h inst=%h want 1/%h/%h",
                 k, inst_valid, inst_pc, inst, exp, rom[exp]);
      end
      exp++;
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] exp;
    do_reset();
    inst_ready = 1'b1;
    exp = '0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (inst_valid) exp++;
      @(negedge clk);
    end
    inst_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (c >= 4) begin
        // Stalled: FIFO full with exp..exp+D-1, fpc frozen at exp+D.
        n_tests++;
        if ({inst_valid, inst_pc, inst, rom_addr} !== {1'b1, exp, rom[exp], exp + AW'(D)}) begin
          n_fail++;
          $display("FAIL bp_stall[%0d]: got v=%b pc=%h inst=%h addr=%h want 1/%h/%h/%h",
                   c, inst_valid, inst_pc, inst, rom_addr, exp, rom[exp], exp + AW'(D));
        end
      end
      @(negedge clk);
    end
    inst_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      n_tests++;
      if ({inst_valid, inst_pc, inst} !== {1'b1, exp, rom[exp]}) begin
        n_fail++;
        $display("FAIL bp_resume[%0d]: got v=%b pc=%h inst=%h want 1/%h/%h",
                 c, inst_valid, inst_pc, inst, exp, rom[exp]);
      end
      exp++;
      @(negedge clk);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    repeat (4) @(negedge clk);  // R+4: PCs 0..2 buffered, PC 3 in flight
    #1;
    n_tests++;
    if ({inst_valid, inst_pc, rom_addr} !== {1'b1, 8'h00, 8'h04}) begin
      n_fail++;
      $display("FAIL redir_pre: got v=%b pc=%h addr=%h want 1/00/04",
               inst_valid, inst_pc, rom_addr);
    end
    redirect_valid = 1'b1;
    redirect_pc = 8'h0A;
    #1;
    n_tests++;
    if (inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_n: got v=%b want 0", inst_valid);
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    inst_ready = 1'b1;
    #1;
    n_tests++;
    if ({inst_valid, rom_addr} !== {1'b0, 8'h0A}) begin
      n_fail++;
      $display("FAIL redir_n1: got v=%b addr=%h want 0/0a", inst_valid, rom_addr);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if (inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_n2: got v=%b want 0", inst_valid);
    end
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      #1;
      n_tests++;
      if ({inst_valid, inst_pc, inst} !== {1'b1, 8'h0A + AW'(k), rom[8'h0A + AW'(k)]}) begin
        n_fail++;
        $display("FAIL redir_seq[%0d]: got v=%b pc=%h inst=%h want 1/%h/%h",
                 k, inst_valid, inst_pc, inst, 8'h0A + AW'(k), rom[8'h0A + AW'(k)]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect_handshake();
    logic [AW-1:0] tgt;
    tgt = AW'($urandom_range(32, 200));
    do_reset();
    inst_ready = 1'b1;
    repeat (4) @(negedge clk);  // streaming, head valid
    redirect_valid = 1'b1;
    redirect_pc = tgt;
    #1;
    n_tests++;
    if (inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hs_no_transfer: got v=%b want 0", inst_valid);
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int k = 1; k < 3; k++) begin
      #1;
      n_tests++;
      if (inst_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL hs_gap[%0d]: got v=%b want 0", k, inst_valid);
      end
      @(negedge clk);
    end
    #1;
    n_tests++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, tgt, rom[tgt]}) begin
      n_fail++;
      $display("FAIL hs_target: got v=%b pc=%h inst=%h want 1/%h/%h",
               inst_valid, inst_pc, inst, tgt, rom[tgt]);
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp;
    do_reset();
    inst_ready = 1'b1;
    repeat (3) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 8'hFE;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    exp = 8'hFE;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_tests++;
      if ({inst_valid, inst_pc, inst} !== {1'b1, exp, rom[exp]}) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got v=%b pc=%h inst=%h want 1/%h/%h",
                 k, inst_valid, inst_pc, inst, exp, rom[exp]);
      end
      exp++;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    inst_ready = 1'b1;
    repeat (4) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 8'h40;
    @(negedge clk);
    redirect_pc = 8'h80;
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_tests++;
      if (inst_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_gap[%0d]: got v=%b want 0", k, inst_valid);
      end
      @(negedge clk);
    end
    for (int k = 0; k < 2; k++) begin
      #1;
      n_tests++;
      if ({inst_valid, inst_pc} !== {1'b1, 8'h80 + AW'(k)}) begin
        n_fail++;
        $display("FAIL b2b_target[%0d]: got v=%b pc=%h want 1/%h",
                 k, inst_valid, inst_pc, 8'h80 + AW'(k));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (5) @(negedge clk);  // R+5: FIFO full, no ready
    #1;
    n_tests++;
    if ({inst_valid, rom_addr} !== {1'b1, 8'h04}) begin
      n_fail++;
      $display("FAIL rmid_full: got v=%b addr=%h want 1/04", inst_valid, rom_addr);
    end
    rst = 1'b1;
    inst_ready = 1'b1;
    @(negedge clk);
    #1;
    n_tests++;
    if ({inst_valid, inst, inst_pc, rom_addr} !== {1'b0, 16'h0000, 8'h00, 8'h00}) begin
      n_fail++;
      $display("FAIL rmid_state: got v=%b inst=%h pc=%h addr=%h want 0/0000/00/00",
               inst_valid, inst, inst_pc, rom_addr);
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    n_tests++;
    if (inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_r1: got v=%b want 0", inst_valid);
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_tests++;
      if ({inst_valid, inst_pc, inst} !== {1'b1, AW'(k), rom[k]}) begin
        n_fail++;
        $display("FAIL rmid_restart[%0d]: got v=%b pc=%h inst=%h want 1/%h/%h",
                 k, inst_valid, inst_pc, inst, AW'(k), rom[k]);
      end
      @(negedge clk);
    end
  endtask

  // Random ready/redirect traffic against an in-order PC model: after a
  // restart to T the core must see T, T+1, ... with inst = rom[pc].
  task automatic test_random();
    logic [AW-1:0] exp;
    int idle;
    for (int i = 0; i < 256; i++) rom[i] = IW'($urandom);
    do_reset();
    exp = '0;
    idle = 0;
    for (int c = 0; c < 3000; c++) begin
      inst_ready = ($urandom_range(9) < 7);
      redirect_valid = ($urandom_range(31) == 0);
      redirect_pc = AW'($urandom);
      #1;
      if (redirect_valid) begin
        n_tests++;
        if (inst_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_redir_valid[%0d]: got v=%b want 0", c, inst_valid);
        end
        exp = redirect_pc;
        idle = 0;
      end else if (inst_valid) begin
        n_tests++;
        if ({inst_pc, inst} !== {exp, rom[exp]}) begin
          n_fail++;
          $display("FAIL rnd_head[%0d]: got pc=%h inst=%h want %h/%h",
                   c, inst_pc, inst, exp, rom[exp]);
        end
        if (inst_ready) begin
          exp++;
          idle = 0;
        end
      end else if (inst_ready) begin
        idle++;
        n_tests++;
        if (idle > 4) begin
          n_fail++;
          $display("FAIL rnd_starve[%0d]: got %0d idle cycles want <=4", c, idle);
          idle = 0;
        end
      end
      @(negedge clk);
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'h3000 | IW'(i);
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect();
    test_redirect_handshake();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
